// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares sram_1rw1r_32_256_8 port 0 between m0 (data) and m1 (fetch); `ARB_ROUND_ROBIN_EN selects round-robin
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SRAM_AW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_we,
  input  logic [3:0]            m0_req_wmask,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  output logic                  m0_rsp_err,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_we,
  input  logic [3:0]            m1_req_wmask,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  output logic                  m1_rsp_err,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [3:0]            sram_wmask0,
  output logic [SRAM_AW-1:0]    sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  logic                  prefer_m0;
  logic                  grant0;
  logic                  grant1;
  logic                  accept;
  logic                  sel_we;
  logic [3:0]            sel_wmask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  misaligned;
  logic                  mem_en;
  logic                  mem_wr;

  // Response pipeline stage: one entry, the macro answers reads one cycle later.
  logic                  rsp_valid_q;
  logic                  rsp_owner_q;
  logic                  rsp_read_q;
  logic                  rsp_err_q;
  logic                  rsp_live;
  logic [DATA_WIDTH-1:0] rsp_data;

  // Address bits above the 1 KiB window are ignored (wrap, no error).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_req_addr[ADDR_WIDTH-1:SRAM_AW+2],
                              m1_req_addr[ADDR_WIDTH-1:SRAM_AW+2]};

`ifdef ARB_ROUND_ROBIN_EN
  // pri_q holds the id of the last granted requester; the other one wins contention.
  logic pri_q;

  // Remember the last accepted requester; reset to m1 so m0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q <= 1'b1;
    end else if (accept) begin
      pri_q <= grant1;
    end
  end

  assign prefer_m0 = pri_q;
`else
  // Fixed priority: m0 always wins contention, m1 may starve.
  assign prefer_m0 = 1'b1;
`endif

  // Grant and request mux; a lone valid is always granted, nothing is granted in reset.
  always_comb begin
    grant0    = !rst && m0_req_valid && (!m1_req_valid || prefer_m0);
    grant1    = !rst && m1_req_valid && !grant0;
    accept    = grant0 || grant1;
    sel_we    = grant1 ? m1_req_we    : m0_req_we;
    sel_wmask = grant1 ? m1_req_wmask : m0_req_wmask;
    sel_addr  = grant1 ? m1_req_addr  : m0_req_addr;
    sel_wdata = grant1 ? m1_req_wdata : m0_req_wdata;
    // Misaligned requests take the slot and answer with an error but never touch the macro.
    misaligned = |sel_addr[1:0];
    mem_en     = accept && !misaligned;
    mem_wr     = mem_en && sel_we;
  end

  assign m0_req_ready = grant0;
  assign m1_req_ready = grant1;

  // Macro command; every field idles at its inactive value when nothing is issued.
  always_comb begin
    sram_csb0   = !mem_en;
    sram_web0   = !mem_wr;
    sram_wmask0 = mem_wr ? sel_wmask : 4'b0000;
    sram_addr0  = mem_en ? sel_addr[SRAM_AW+1:2] : '0;
    sram_din0   = mem_wr ? sel_wdata : '0;
  end

  // Capture who issued the accepted access so the reply follows it, not the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
      rsp_read_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      rsp_owner_q <= grant1;
      rsp_read_q  <= !sel_we;
      rsp_err_q   <= misaligned;
    end
  end

  // Route the response; read data passes straight from the macro, zero otherwise.
  always_comb begin
    rsp_live     = !rst && rsp_valid_q;
    rsp_data     = (rsp_live && rsp_read_q && !rsp_err_q) ? sram_dout0 : '0;
    m0_rsp_valid = rsp_live && !rsp_owner_q;
    m1_rsp_valid = rsp_live && rsp_owner_q;
    m0_rsp_err   = m0_rsp_valid && rsp_err_q;
    m1_rsp_err   = m1_rsp_valid && rsp_err_q;
    m0_rsp_rdata = m0_rsp_valid ? rsp_data : '0;
    m1_rsp_rdata = m1_rsp_valid ? rsp_data : '0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_valid, m0_req_ready, m0_req_we;
  logic [3:0]  m0_req_wmask;
  logic [31:0] m0_req_addr, m0_req_wdata;
  logic        m0_rsp_valid, m0_rsp_err;
  logic [31:0] m0_rsp_rdata;
  logic        m1_req_valid, m1_req_ready, m1_req_we;
  logic [3:0]  m1_req_wmask;
  logic [31:0] m1_req_addr, m1_req_wdata;
  logic        m1_rsp_valid, m1_rsp_err;
  logic [31:0] m1_rsp_rdata;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mem [0:255];
  logic        rr_mode;
  logic        exp0;
  logic        prev0;

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_wmask(m0_req_wmask), .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_wmask(m1_req_wmask), .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // Behavioural model of the macro port 0, preloaded while in reset.
  always @(posedge clk) begin
    if (rst) begin
      mem[2] <= 32'hAABB_CCDD;
      mem[4] <= 32'hDEAD_BEEF;
    end else if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    m0_req_valid = 0; m0_req_we = 0; m0_req_wmask = 0; m0_req_addr = 0; m0_req_wdata = 0;
    m1_req_valid = 0; m1_req_we = 0; m1_req_wmask = 0; m1_req_addr = 0; m1_req_wdata = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    sram_dout0 = 32'h0;
    idle();
    rst = 1;
    m0_req_valid = 1; m0_req_addr = 32'h10;
    step(); step(); step(); #1;
    chk("rst_m0_ready", {31'b0, m0_req_ready}, 0);
    chk("rst_m1_ready", {31'b0, m1_req_ready}, 0);
    chk("rst_csb0", {31'b0, sram_csb0}, 1);
    chk("rst_web0", {31'b0, sram_web0}, 1);
    chk("rst_wmask0", {28'b0, sram_wmask0}, 0);
    chk("rst_addr0", {24'b0, sram_addr0}, 0);
    chk("rst_din0", sram_din0, 0);
    chk("rst_m0_rsp_valid", {31'b0, m0_rsp_valid}, 0);
    chk("rst_m0_rsp_rdata", m0_rsp_rdata, 0);

    // T1: idle after reset
    step(); rst = 0; idle();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t1_ready", {30'b0, m0_req_ready, m1_req_ready}, 0);
      chk("t1_csb0", {31'b0, sram_csb0}, 1);
      chk("t1_rsp_valid", {30'b0, m0_rsp_valid, m1_rsp_valid}, 0);
      step();
    end

    // T2: m1 read of word 4
    m1_req_valid = 1; m1_req_addr = 32'h10; #1;
    chk("t2_m1_ready", {31'b0, m1_req_ready}, 1);
    chk("t2_m0_ready", {31'b0, m0_req_ready}, 0);
    chk("t2_addr0", {24'b0, sram_addr0}, 4);
    chk("t2_csb0", {31'b0, sram_csb0}, 0);
    chk("t2_web0", {31'b0, sram_web0}, 1);
    step(); idle(); #1;
    chk("t2_m1_rsp_valid", {31'b0, m1_rsp_valid}, 1);
    chk("t2_m1_rsp_rdata", m1_rsp_rdata, 32'hDEAD_BEEF);
    chk("t2_m1_rsp_err", {31'b0, m1_rsp_err}, 0);
    chk("t2_m0_rsp_valid", {31'b0, m0_rsp_valid}, 0);

    // T3: m0 partial write of word 2, then m1 reads it back
    step();
    m0_req_valid = 1; m0_req_we = 1; m0_req_addr = 32'h8; m0_req_wdata = 32'h1122_3344; m0_req_wmask = 4'b0011; #1;
    chk("t3_m0_ready", {31'b0, m0_req_ready}, 1);
    chk("t3_csb0", {31'b0, sram_csb0}, 0);
    chk("t3_web0", {31'b0, sram_web0}, 0);
    chk("t3_wmask0", {28'b0, sram_wmask0}, 4'b0011);
    chk("t3_addr0", {24'b0, sram_addr0}, 2);
    chk("t3_din0", sram_din0, 32'h1122_3344);
    step(); idle(); m1_req_valid = 1; m1_req_addr = 32'h8; #1;
    chk("t3_m0_wr_rsp_valid", {31'b0, m0_rsp_valid}, 1);
    chk("t3_m0_wr_rsp_rdata", m0_rsp_rdata, 0);
    chk("t3_m0_wr_rsp_err", {31'b0, m0_rsp_err}, 0);
    chk("t3_m1_ready", {31'b0, m1_req_ready}, 1);
    step(); idle(); #1;
    chk("t3_m1_rsp_valid", {31'b0, m1_rsp_valid}, 1);
    chk("t3_m1_rsp_rdata", m1_rsp_rdata, 32'hAABB_3344);

    // T5: misaligned m0 read
    step(); m0_req_valid = 1; m0_req_addr = 32'h6; #1;
    chk("t5_m0_ready", {31'b0, m0_req_ready}, 1);
    chk("t5_csb0", {31'b0, sram_csb0}, 1);
    step(); idle(); #1;
    chk("t5_m0_rsp_valid", {31'b0, m0_rsp_valid}, 1);
    chk("t5_m0_rsp_err", {31'b0, m0_rsp_err}, 1);
    chk("t5_m0_rsp_rdata", m0_rsp_rdata, 0);

    // Address wrap: 0x410 maps to word 4 with no error
    step(); m1_req_valid = 1; m1_req_addr = 32'h0000_0410; #1;
    chk("wrap_addr0", {24'b0, sram_addr0}, 4);
    step(); idle(); #1;
    chk("wrap_rdata", m1_rsp_rdata, 32'hDEAD_BEEF);
    chk("wrap_err", {31'b0, m1_rsp_err}, 0);

    // wmask=0 write is a no-op that still responds
    step(); m1_req_valid = 1; m1_req_we = 1; m1_req_addr = 32'h10; m1_req_wdata = 32'h5555_5555; #1;
    chk("nop_csb0", {31'b0, sram_csb0}, 0);
    chk("nop_web0", {31'b0, sram_web0}, 0);
    chk("nop_wmask0", {28'b0, sram_wmask0}, 0);
    step(); idle(); #1;
    chk("nop_rsp_valid", {31'b0, m1_rsp_valid}, 1);
    chk("nop_rsp_err", {31'b0, m1_rsp_err}, 0);

    // T4: contention for 6 cycles
    step();
    m0_req_valid = 1; m0_req_addr = 32'h10;
    m1_req_valid = 1; m1_req_addr = 32'h8;
    prev0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp0 = rr_mode ? (i % 2 == 0) : 1'b1;
      chk("t4_m0_ready", {31'b0, m0_req_ready}, {31'b0, exp0});
      chk("t4_m1_ready", {31'b0, m1_req_ready}, {31'b0, !exp0});
      if (i > 0) begin
        if (prev0) begin
          chk("t4_m0_rsp_valid", {31'b0, m0_rsp_valid}, 1);
          chk("t4_m0_rsp_rdata", m0_rsp_rdata, 32'hDEAD_BEEF);
        end else begin
          chk("t4_m1_rsp_valid", {31'b0, m1_rsp_valid}, 1);
          chk("t4_m1_rsp_rdata", m1_rsp_rdata, 32'hAABB_3344);
        end
      end
      prev0 = exp0;
      step();
    end
    idle(); #1;
    chk("t4_last_m0_rsp", {31'b0, m0_rsp_valid}, {31'b0, prev0});
    chk("t4_last_m1_rsp", {31'b0, m1_rsp_valid}, {31'b0, !prev0});

    // T6: reset drops a pending response; m0 wins first afterwards
    step(); m0_req_valid = 1; m0_req_addr = 32'h10; #1;
    chk("t6_m0_ready", {31'b0, m0_req_ready}, 1);
    step(); idle(); rst = 1; #1;
    chk("t6_rsp_in_rst", {31'b0, m0_rsp_valid}, 0);
    step(); rst = 0; #1;
    chk("t6_rsp_after_rst", {30'b0, m0_rsp_valid, m1_rsp_valid}, 0);
    step();
    m0_req_valid = 1; m0_req_addr = 32'h10;
    m1_req_valid = 1; m1_req_addr = 32'h8; #1;
    chk("t6_m0_first", {31'b0, m0_req_ready}, 1);
    chk("t6_m1_wait", {31'b0, m1_req_ready}, 0);
    step(); idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
